// File: rtl/mem_responder_pkg.sv
// Shared definitions for the single-outstanding memory responder: default base address,
// FSM state encoding and the latched request record.
package mem_responder_pkg;

   localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic        is_data;
      logic        wen;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] wmask;
   } req_t;

   function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
      return (addr - base) >> 3;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port DEPTH x 64 RAM with per-bit write mask.
// Latency: read data registered one edge after en; backpressure: none, always accepts.
module mem_array #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [63:0]   wdata,
   input  logic [63:0]   wmask,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];

   // Read-first: rdata returns the pre-write word, which is never consumed for stores.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder serving one fetch or load/store at a time, data port has priority.
// Latency: response valid LATENCY cycles after accept; backpressure: holds RESP until resp_ready.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int          DEPTH   = 4096,
   parameter int          LATENCY = 2,
   parameter logic [63:0] BASE    = PC_START
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req_valid,
   output logic        inst_req_ready,
   input  logic [63:0] inst_req_addr,
   output logic        inst_resp_valid,
   input  logic        inst_resp_ready,
   output logic [63:0] inst_resp_data,
   input  logic        data_req_valid,
   output logic        data_req_ready,
   input  logic [63:0] data_req_addr,
   input  logic        data_req_wen,
   input  logic [63:0] data_req_wdata,
   input  logic [63:0] data_req_wmask,
   output logic        data_resp_valid,
   input  logic        data_resp_ready,
   output logic [63:0] data_resp_rdata,
   output logic        data_resp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]  state;
   logic [3:0]  cnt;
   req_t        lat;
   req_t        cur;
   logic        accept;
   logic [63:0] index;
   logic        err;
   logic        mem_go;
   logic        mem_we;
   logic [63:0] ram_q;
   logic        resp_take;

   assign data_req_ready = (state == ST_IDLE);
   assign inst_req_ready = (state == ST_IDLE) && !data_req_valid;
   assign accept         = (state == ST_IDLE) && (data_req_valid || inst_req_valid);

   // In IDLE the request is taken straight from the ports so LATENCY==1 can hit the RAM on the accept edge.
   always_comb begin
      cur = lat;
      if (state == ST_IDLE) begin
         cur.is_data = data_req_valid;
         cur.wen     = data_req_valid && data_req_wen;
         cur.addr    = data_req_valid ? data_req_addr : inst_req_addr;
         cur.wdata   = data_req_wdata;
         cur.wmask   = data_req_wmask;
      end
   end

   assign index  = word_index(cur.addr, BASE);
   assign err    = (cur.addr < BASE) || (index >= 64'(DEPTH));
   assign mem_go = ((state == ST_WAIT) && (cnt <= 4'd1)) || (accept && (LATENCY == 1));
   assign mem_we = mem_go && cur.wen && !err;

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem_array (
      .clk   (clk),
      .en    (mem_go),
      .we    (mem_we),
      .addr  (index[AW-1:0]),
      .wdata (cur.wdata),
      .wmask (cur.wmask),
      .rdata (ram_q)
   );

   assign data_resp_valid = (state == ST_RESP) && lat.is_data;
   assign inst_resp_valid = (state == ST_RESP) && !lat.is_data;
   assign data_resp_err   = data_resp_valid && err;
   assign data_resp_rdata = (data_resp_valid && !lat.wen && !err) ? ram_q : 64'h0;
   assign inst_resp_data  = (inst_resp_valid && !err) ? ram_q : 64'h0;
   assign resp_take       = lat.is_data ? data_resp_ready : inst_resp_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
         lat   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat   <= cur;
                  cnt   <= 4'(LATENCY - 1);
                  state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt <= 4'd1) begin
                  cnt   <= 4'd0;
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (resp_take) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder against an array-based memory model.
module tb_mem_responder;
   import mem_responder_pkg::*;

   localparam int          DEPTH = 4096;
   localparam int          LAT   = 2;
   localparam logic [63:0] BASE  = PC_START;
   localparam logic [63:0] FULL  = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req_valid = 1'b0;
   logic        inst_req_ready;
   logic [63:0] inst_req_addr = '0;
   logic        inst_resp_valid;
   logic        inst_resp_ready = 1'b0;
   logic [63:0] inst_resp_data;
   logic        data_req_valid = 1'b0;
   logic        data_req_ready;
   logic [63:0] data_req_addr = '0;
   logic        data_req_wen = 1'b0;
   logic [63:0] data_req_wdata = '0;
   logic [63:0] data_req_wmask = '0;
   logic        data_resp_valid;
   logic        data_resp_ready = 1'b0;
   logic [63:0] data_resp_rdata;
   logic        data_resp_err;

   mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE(BASE)) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_req_valid  (inst_req_valid),
      .inst_req_ready  (inst_req_ready),
      .inst_req_addr   (inst_req_addr),
      .inst_resp_valid (inst_resp_valid),
      .inst_resp_ready (inst_resp_ready),
      .inst_resp_data  (inst_resp_data),
      .data_req_valid  (data_req_valid),
      .data_req_ready  (data_req_ready),
      .data_req_addr   (data_req_addr),
      .data_req_wen    (data_req_wen),
      .data_req_wdata  (data_req_wdata),
      .data_req_wmask  (data_req_wmask),
      .data_resp_valid (data_resp_valid),
      .data_resp_ready (data_resp_ready),
      .data_resp_rdata (data_resp_rdata),
      .data_resp_err   (data_resp_err)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic [63:0] model_mem [longint];
   logic [64:0] exp_d_q [$];
   logic [63:0] exp_i_q [$];
   longint      acc_d_q [$];
   longint      acc_i_q [$];
   longint      d_done_cyc = -1;
   bit          hold_d = 0;

   longint pool [8] = '{0, 1, 2, 3, 7, 100, 2047, DEPTH - 1};

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit m_err(input logic [63:0] a);
      if (a < BASE) return 1'b1;
      return ((a - BASE) / 8) >= 64'(DEPTH);
   endfunction

   function automatic longint m_idx(input logic [63:0] a);
      return longint'((a - BASE) / 8);
   endfunction

   function automatic logic [63:0] m_read(input longint i);
      return model_mem.exists(i) ? model_mem[i] : 64'h0;
   endfunction

   function automatic void push_data(input logic [63:0] a, input bit w, input logic [63:0] d,
                                     input logic [63:0] m, input longint c);
      bit e = m_err(a);
      if (w) begin
         if (!e) model_mem[m_idx(a)] = (m_read(m_idx(a)) & ~m) | (d & m);
         exp_d_q.push_back({e, 64'h0});
      end else begin
         exp_d_q.push_back({e, e ? 64'h0 : m_read(m_idx(a))});
      end
      acc_d_q.push_back(c);
   endfunction

   function automatic void push_inst(input logic [63:0] a, input longint c);
      exp_i_q.push_back(m_err(a) ? 64'h0 : m_read(m_idx(a)));
      acc_i_q.push_back(c);
   endfunction

   task automatic issue(input bit do_d, input logic [63:0] da, input bit dw, input logic [63:0] dd,
                        input logic [63:0] dm, input bit do_i, input logic [63:0] ia, input bit push,
                        output longint d_acc, output longint i_acc);
      bit pd = do_d;
      bit pi = do_i;
      bit ad, ai;
      int n = 0;
      d_acc = -1;
      i_acc = -1;
      data_req_valid = pd;
      data_req_addr  = da;
      data_req_wen   = dw;
      data_req_wdata = dd;
      data_req_wmask = dm;
      inst_req_valid = pi;
      inst_req_addr  = ia;
      while ((pd || pi) && n < 200) begin
         @(negedge clk);
         ad = pd && data_req_ready;
         ai = pi && inst_req_ready;
         if (ad) begin
            d_acc = cyc;
            if (push) push_data(da, dw, dd, dm, cyc);
         end
         if (ai) begin
            i_acc = cyc;
            if (push) push_inst(ia, cyc);
         end
         @(posedge clk);
         #1;
         if (ad) begin pd = 0; data_req_valid = 1'b0; end
         if (ai) begin pi = 0; inst_req_valid = 1'b0; end
         n++;
      end
      if (pd || pi) begin
         checks++;
         failures++;
         $display("FAIL issue_timeout: request pending %0b%0b required accepted", pd, pi);
         data_req_valid = 1'b0;
         inst_req_valid = 1'b0;
      end
   endtask

   task automatic dreq(input logic [63:0] a, input bit w, input logic [63:0] d, input logic [63:0] m);
      longint x, y;
      issue(1, a, w, d, m, 0, 64'h0, 1, x, y);
   endtask

   task automatic ireq(input logic [63:0] a);
      longint x, y;
      issue(0, 64'h0, 0, 64'h0, 64'h0, 1, a, 1, x, y);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_d_q.size() != 0 || exp_i_q.size() != 0 || data_resp_valid || inst_resp_valid) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_d_q.size() != 0 || exp_i_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: pending %0d/%0d responses required 0", exp_d_q.size(), exp_i_q.size());
         exp_d_q.delete(); exp_i_q.delete(); acc_d_q.delete(); acc_i_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rand_addr();
      if ($urandom_range(0, 5) == 0) begin
         case ($urandom_range(0, 3))
            0: return BASE - 64'd8;
            1: return BASE + 64'(DEPTH) * 8;
            2: return 64'h0;
            default: return 64'hFFFF_FFFF_FFFF_FFF8;
         endcase
      end
      return BASE + 64'(pool[$urandom_range(0, 7)]) * 8 + 64'($urandom_range(0, 7));
   endfunction

   // Response-side initiator: random acceptance unless a directed stall is requested.
   initial forever begin
      @(posedge clk);
      #1;
      data_resp_ready = hold_d ? 1'b0 : ($urandom_range(0, 3) != 0);
      inst_resp_ready = ($urandom_range(0, 3) != 0);
   end

   // Monitor: pops the scoreboard on each new response, checks latency and stall stability.
   bit          d_pend = 0, i_pend = 0;
   logic [64:0] d_saved, i_saved;
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         d_pend = 0;
         i_pend = 0;
      end else begin
         if (data_resp_valid || inst_resp_valid)
            chk("req_ready_busy", {63'h0, data_req_ready, inst_req_ready}, 65'h0);
         if (data_resp_valid) begin
            if (!d_pend) begin
               if (exp_d_q.size() == 0) chk("data_unexpected", 65'h1, 65'h0);
               else begin
                  chk("data_resp", {data_resp_err, data_resp_rdata}, exp_d_q.pop_front());
                  chk("data_latency", 65'(cyc - acc_d_q.pop_front()), 65'(LAT));
               end
            end else begin
               chk("data_stall_stable", {data_resp_err, data_resp_rdata}, d_saved);
            end
            d_saved = {data_resp_err, data_resp_rdata};
            if (data_resp_ready) d_done_cyc = cyc;
         end else if (d_pend) begin
            chk("data_valid_dropped", 65'h0, 65'h1);
         end
         d_pend = data_resp_valid && !data_resp_ready;

         if (inst_resp_valid) begin
            if (!i_pend) begin
               if (exp_i_q.size() == 0) chk("inst_unexpected", 65'h1, 65'h0);
               else begin
                  chk("inst_resp", {1'b0, inst_resp_data}, {1'b0, exp_i_q.pop_front()});
                  chk("inst_latency", 65'(cyc - acc_i_q.pop_front()), 65'(LAT));
               end
            end else begin
               chk("inst_stall_stable", {1'b0, inst_resp_data}, i_saved);
            end
            i_saved = {1'b0, inst_resp_data};
         end else if (i_pend) begin
            chk("inst_valid_dropped", 65'h0, 65'h1);
         end
         i_pend = inst_resp_valid && !inst_resp_ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, required finished");
      $fatal(1, "timeout");
   end

   initial begin
      longint da, ia;
      logic [63:0] old_val, a, m;
      int k;

      repeat (3) @(negedge clk);
      chk("rst_resp_valid", {63'h0, data_resp_valid, inst_resp_valid}, 65'h0);
      chk("rst_resp_data", {data_resp_err, data_resp_rdata}, 65'h0);
      chk("rst_inst_data", {1'b0, inst_resp_data}, 65'h0);
      chk("rst_data_ready", {64'h0, data_req_ready}, 65'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_inst_ready", {64'h0, inst_req_ready}, 65'h1);

      // Known contents for every pool word so reads never depend on RAM power-up values.
      for (int i = 0; i < 8; i++)
         dreq(BASE + 64'(pool[i]) * 8, 1, {$urandom, $urandom}, FULL);

      dreq(BASE + 64'd8, 1, 64'h1122334455667788, FULL);
      dreq(BASE + 64'd8, 0, 64'h0, 64'h0);
      dreq(BASE + 64'd16, 1, 64'h0, FULL);
      dreq(BASE + 64'd16, 1, 64'hAB00, 64'h0000_0000_0000_FF00);
      dreq(BASE + 64'd16, 0, 64'h0, 64'h0);

      dreq(BASE + 64'(DEPTH) * 8, 0, 64'h0, 64'h0);
      dreq(BASE - 64'd8, 0, 64'h0, 64'h0);
      dreq(BASE + 64'(DEPTH) * 8, 1, FULL, FULL);
      dreq(BASE - 64'd8, 1, FULL, FULL);
      dreq(BASE + 64'(DEPTH - 1) * 8, 0, 64'h0, 64'h0);
      ireq(BASE + 64'd12);
      ireq(BASE - 64'd8);
      wait_idle();

      // Simultaneous requests: data wins, fetch follows on the first idle cycle.
      issue(1, BASE + 64'd24, 0, 64'h0, 64'h0, 1, BASE + 64'd8, 1, da, ia);
      chk("prio_data_first", {64'h0, (da >= 0) && (ia > da)}, 65'h1);
      chk("prio_inst_after_resp", 65'(ia), 65'(d_done_cyc + 1));
      wait_idle();

      hold_d = 1;
      dreq(BASE + 64'd8, 0, 64'h0, 64'h0);
      k = 0;
      while (!data_resp_valid && k < 20) begin @(negedge clk); k++; end
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid_held", {64'h0, data_resp_valid}, 65'h1);
         @(negedge clk);
      end
      hold_d = 0;
      wait_idle();

      old_val = model_mem[3];
      issue(1, BASE + 64'd24, 1, ~old_val, FULL, 0, 64'h0, 0, da, ia);
      rst = 1'b0;
      #1;
      chk("rst_wait_valid", {63'h0, data_resp_valid, inst_resp_valid}, 65'h0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      dreq(BASE + 64'd24, 0, 64'h0, 64'h0);
      wait_idle();

      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 4);
         a = rand_addr();
         case ($urandom_range(0, 2))
            0: m = FULL;
            1: m = 64'hFF << (8 * $urandom_range(0, 7));
            default: m = {$urandom, $urandom};
         endcase
         if (k <= 2) dreq(a, k[0], {$urandom, $urandom}, m);
         else if (k == 3) ireq(a);
         else issue(1, a, $urandom_range(0, 1) == 1, {$urandom, $urandom}, m, 1, rand_addr(), 1, da, ia);
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
